// File: rtl/crc16_stream.sv
`timescale 1ns/1ps
// Streaming CRC-16 (MSB-first, no reflection), DATA_W/8 bytes folded per accepted beat.
// Result appears the cycle after the eof beat and is held in HOLD with s_ready=0 until crc_ready.
module crc16_stream #(
  parameter int          DATA_W = 64,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_sof,
  input  logic                s_eof,
  input  logic                chk_en,
  input  logic [15:0]         chk_crc,
  output logic                crc_valid,
  input  logic                crc_ready,
  output logic [15:0]         crc_out,
  output logic                crc_match,
  output logic                frame_err
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state_q, state_d;
  logic [15:0]   crc_q, crc_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   crc_out_q, crc_out_d;
  logic          ferr_q, ferr_d;
  logic          chk_en_q, chk_en_d;
  logic [15:0]   chk_crc_q, chk_crc_d;

  logic          accept;
  logic          fin;
  logic          run;
  logic          keep_err;
  logic [NB-1:0] byte_en;
  logic [15:0]   crc_upd;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  assign accept = s_valid & rdy_q;

  // Only the low contiguous run of keep bits counts; anything above a gap is a keep error.
  always_comb begin
    byte_en  = '1;
    keep_err = 1'b0;
    run      = 1'b1;
    if (s_eof) begin
      for (int k = 0; k < NB; k++) begin
        run        = run & s_keep[k];
        byte_en[k] = run;
      end
      keep_err = (byte_en != s_keep);
    end
  end

  always_comb begin
    crc_upd = ((state_q == IDLE) || s_sof) ? INIT : crc_q;
    for (int k = 0; k < NB; k++) begin
      if (byte_en[k]) crc_upd = crc_byte(crc_upd, s_data[8*k +: 8]);
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    err_d     = err_q;
    crc_out_d = crc_out_q;
    ferr_d    = ferr_q;
    chk_en_d  = chk_en_q;
    chk_crc_d = chk_crc_q;
    fin       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            crc_d   = crc_upd;
            state_d = ACCUM;
            fin     = s_eof;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          crc_d = crc_upd;
          if (s_sof) err_d = 1'b1;
          fin = s_eof;
        end
      end
      HOLD: begin
        if (crc_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d   = HOLD;
      crc_out_d = crc_upd;
      ferr_d    = err_d | keep_err;
      chk_en_d  = chk_en;
      chk_crc_d = chk_crc;
    end
    rdy_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      crc_out_q <= 16'h0000;
      ferr_q    <= 1'b0;
      chk_en_q  <= 1'b0;
      chk_crc_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
      crc_out_q <= crc_out_d;
      ferr_q    <= ferr_d;
      chk_en_q  <= chk_en_d;
      chk_crc_q <= chk_crc_d;
    end
  end

  assign s_ready   = rdy_q;
  assign crc_valid = (state_q == HOLD);
  assign crc_out   = crc_out_q;
  assign crc_match = chk_en_q & (crc_out_q == chk_crc_q);
  assign frame_err = ferr_q;

endmodule

// File: doc/crc16_stream.md
CRC16_STREAM -- requirements
Module: crc16_stream

Interface
REQ-001 Parameter DATA_W, default 64: input word width in bits; SHALL be a multiple of 8 in the range 8..64.
REQ-002 Parameter POLY, default 16'h1021: CRC-16 generator polynomial, with the implicit x^16 term omitted.
REQ-003 Parameter INIT, default 16'hFFFF: CRC register value at frame start.
REQ-004 clk  in  1  single clock for the whole block; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 s_valid  in  1  input beat valid.
REQ-007 s_ready  out  1  block can accept a beat.
REQ-008 s_data  in  DATA_W  input bytes; byte k is s_data[8k+7:8k], and byte 0 is processed first.
REQ-009 s_keep  in  DATA_W/8  byte-valid mask; ignored (treated all-ones) unless s_eof=1.
REQ-010 s_sof  in  1  beat is the first of a frame.
REQ-011 s_eof  in  1  beat is the last of a frame.
REQ-012 chk_en  in  1  sampled with the eof beat; selects check mode.
REQ-013 chk_crc  in  16  expected CRC, sampled with the eof beat.
REQ-014 crc_valid  out  1  result available.
REQ-015 crc_ready  in  1  consumer accepts the result.
REQ-016 crc_out  out  16  final CRC of the frame.
REQ-017 crc_match  out  1  crc_out==chk_crc when check mode was selected; 0 otherwise.
REQ-018 frame_err  out  1  protocol error detected in the reported frame.

Function
REQ-019 A beat SHALL be accepted on a cycle with s_valid=1 and s_ready=1.
REQ-020 Bits SHALL be processed MSB-first within each byte; there SHALL be no reflection and no final XOR.
REQ-021 The CRC of all valid bytes of an accepted beat SHALL be computed in one cycle, combinationally unrolled over DATA_W/8 byte steps.
REQ-022 States SHALL be IDLE, ACCUM and HOLD.
REQ-023 IDLE: s_ready=1.
    - Accepted beat with s_sof=1: CRC register loaded with the update of INIT over the beat's bytes.
    - If s_eof=1 on that beat, the next state is HOLD; otherwise the next state is ACCUM.
    - Accepted beat with s_sof=0: beat discarded, sticky error flag set, state remains IDLE.
REQ-024 ACCUM: s_ready=1.
    - Accepted beat: CRC register updated.
    - s_eof=1 moves the state to HOLD.
    - s_sof=1 mid-frame restarts the frame from INIT with this beat and sets the sticky error flag.
REQ-025 HOLD: s_ready=0, crc_valid=1.
    - crc_out, crc_match and frame_err SHALL be held stable until crc_valid=1 and crc_ready=1 coincide.
    - After that handshake, the next state is IDLE and the sticky error flag is cleared.
REQ-026 Result latency: crc_valid SHALL rise on the first cycle after the eof beat is accepted.
REQ-027 Throughput: the block SHALL accept one beat per cycle while in ACCUM; a single-beat frame SHALL occupy at least 2 cycles.
REQ-028 Eof-beat s_keep SHALL be contiguous from bit 0; bytes with keep=0 SHALL NOT affect the CRC.
REQ-029 s_keep all-zero on the eof beat SHALL be legal and contribute no bytes; a frame consisting of that beat alone yields crc_out=INIT.
REQ-030 A non-contiguous eof-beat s_keep SHALL process only the low contiguous run of ones and SHALL set frame_err.
REQ-031 chk_en and chk_crc SHALL be registered on the eof beat.
REQ-032 crc_match SHALL equal chk_en AND (final CRC == chk_crc).
REQ-033 frame_err SHALL report the sticky error flag OR'd with the keep error of the reported frame.
REQ-034 s_data, s_sof, s_eof and s_keep SHALL be ignored on cycles where the beat is not accepted.
REQ-035 Backpressure on the output side SHALL stall the input only through s_ready=0 in HOLD; no data SHALL be lost.

Reset
REQ-036 While rst=0 at a clock edge, the block SHALL enter IDLE with:
    - CRC register = INIT
    - s_ready=0 during reset, 1 on the first cycle after rst returns high
    - crc_valid=0, crc_out=16'h0000, crc_match=0, frame_err=0
    - sticky error cleared
REQ-037 Reset SHALL take priority over all activity; a frame or a held result in progress SHALL be discarded without a result.

Verification
REQ-038 DATA_W=64 frame:
    - Stimulus: beat 1 = 64'h3837363534333231, sof=1, eof=0; beat 2 = s_data[7:0]=8'h39, keep=8'h01, eof=1.
    - Required response: crc_valid one cycle after beat 2 with crc_out=16'h29B1, frame_err=0.
REQ-039 DATA_W=8, same nine bytes 0x31..0x39, one byte per cycle -> crc_out=16'h29B1 (width equivalence).
REQ-040 Check mode:
    - Same frame as REQ-038 with chk_en=1, chk_crc=16'h29B1 -> crc_match=1.
    - Repeat with chk_crc=16'h29B0 -> crc_match=0.
REQ-041 Single beat with sof=1, eof=1, keep=0 -> crc_out=16'hFFFF.
    - Then hold crc_ready=0 for 5 cycles: s_ready=0 and outputs stable throughout; the result is consumed on the first cycle with crc_ready=1.
REQ-042 Error cases:
    - Beat without sof in IDLE, then the REQ-038 frame -> crc_out=16'h29B1, frame_err=1.
    - Keep=8'h05 on an eof beat -> frame_err=1.
REQ-043 Reset mid-frame:
    - Stimulus: rst=0 asserted after beat 1 of the REQ-038 frame, then the full frame resent.
    - Required response: no crc_valid from the aborted frame; the resent frame gives crc_out=16'h29B1.
